riscv_pc_ctrl: RTL and testbench
================================

// Module: riscv_pc_ctrl
// PURPOSE
//  Parametrised PC controller for the multi-cycle NPC core; successor to the single-cycle next-PC adder.
//  Holds the architectural PC, offers it to the IFU via valid/ready, waits for the instruction to commit,
//  then resolves the next PC (seq/jal/jalr/cond-branch/trap/mret) and re-issues. Sits between IFU and EXU/CSR.
// PARAMETERS
//  XLEN       32             address/data width
//  RESET_VEC  32'h8000_0000  PC loaded on reset (XLEN bits)
//  BR_OP_W    3              width of branch_op_i
// PORTS
//  clk          in   1        core clock, all state on posedge
//  rst          in   1        reset, synchronous, active-low (0 = reset)
//  pc_valid_o   out  1        pc_o is a fetch request to IFU
//  pc_ready_i   in   1        IFU accepts pc_o this cycle
//  pc_o         out  XLEN     current architectural PC
//  commit_i     in   1        instruction at pc_o finishes this cycle; resolve inputs valid
//  branch_op_i  in   BR_OP_W  000 seq, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt(u), 111 bge(u)
//  zero_i       in   1        ALU compare result == 0
//  less_i       in   1        ALU compare result less-than
//  imm_i        in   XLEN     sign-extended immediate
//  rs1_val_i    in   XLEN     rs1 value (jalr base)
//  trap_i       in   1        ecall/exception at commit
//  trap_vec_i   in   XLEN     mtvec target
//  mret_i       in   1        mret at commit
//  mepc_i       in   XLEN     mret target
//  npc_o        out  XLEN     combinational resolved next PC (valid when commit_i in EXEC)
//  redirect_o   out  1        1-cycle pulse: committed PC != pc_o+4
//  misalign_o   out  1        1-cycle pulse, only with NPC_MISALIGN_CHK_EN, else tied 0
// BEHAVIOUR
//  Reset (rst==0 at posedge): pc_o=RESET_VEC, state=BOOT, pc_valid_o=0, redirect_o=0, misalign_o=0.
//  FSM: BOOT -> FETCH unconditionally next cycle (one dead cycle after reset release).
//   FETCH: pc_valid_o=1; pc_o stable while pc_ready_i=0; pc_valid_o&&pc_ready_i -> EXEC.
//   EXEC : pc_valid_o=0; wait commit_i; on commit_i: pc_o<=npc_o, -> FETCH next cycle.
//  commit_i in BOOT/FETCH ignored (no PC change). Fetch-to-refetch minimum: 2 cycles per instruction.
//  npc_o priority: trap_i -> trap_vec_i; else mret_i -> mepc_i; else branch_op_i:
//   000 pc+4; 001 pc+imm; 010 (rs1+imm)&~1 (LSB cleared);
//   100 zero?pc+imm:pc+4; 101 zero?pc+4:pc+imm; 110 less?pc+imm:pc+4; 111 less?pc+4:pc+imm;
//   011 and any undefined code -> pc+4.
//  All adds modulo 2^XLEN (wrap silently, e.g. pc=FFFF_FFFC seq -> 0000_0000).
//  trap_i and mret_i both 1: trap wins. Branch fields ignored when trap_i|mret_i.
//  redirect_o registered: asserted the cycle after commit when loaded PC != old pc+4; 0 otherwise.
//  Reset mid-EXEC/FETCH: committed state discarded, outputs return to reset values next cycle.
// CONFIGURATION
//  NPC_MISALIGN_CHK_EN defined: if resolved target (not trap/mret) has target[1:0]!=0, PC loads
//   trap_vec_i instead, misalign_o pulses 1 cycle (same cycle as redirect_o), redirect_o=1.
//  Undefined: no check; misaligned targets loaded as computed; misalign_o constant 0.
// TESTING
//  Reset release, pc_ready_i=1 -> cycle0 valid=0, cycle1 valid=1 pc_o=8000_0000.
//  pc_ready_i low 5 cycles in FETCH -> pc_o stable 8000_0000, valid held 1, no state change.
//  pc=8000_0010, op=100, zero=1, imm=-8, commit -> pc_o=8000_0008, redirect_o=1; zero=0 -> 8000_0014, redirect 0.
//  op=010, rs1=8000_1003, imm=2 -> pc_o=8000_1004; trap_i=mret_i=1, mtvec=8000_0100 -> pc_o=8000_0100.
//  pc=FFFF_FFFC op=000 commit -> pc_o=0000_0000, redirect_o=0; commit_i in FETCH -> pc unchanged.
//  With NPC_MISALIGN_CHK_EN: op=001 pc=8000_0000 imm=2 -> pc_o=trap_vec_i, misalign_o=1 one cycle.

Source files
------------

// File: rtl/riscv_pc_ctrl.sv
// PC controller for the multi-cycle NPC core: BOOT/FETCH/EXEC handshake and next-PC resolve.
// Optional NPC_MISALIGN_CHK_EN: misaligned resolved targets divert to trap_vec_i and pulse misalign_o.
module riscv_pc_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 'h8000_0000,
  parameter int BR_OP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pc_valid_o,
  input  logic               pc_ready_i,
  output logic [XLEN-1:0]    pc_o,
  input  logic               commit_i,
  input  logic [BR_OP_W-1:0] branch_op_i,
  input  logic               zero_i,
  input  logic               less_i,
  input  logic [XLEN-1:0]    imm_i,
  input  logic [XLEN-1:0]    rs1_val_i,
  input  logic               trap_i,
  input  logic [XLEN-1:0]    trap_vec_i,
  input  logic               mret_i,
  input  logic [XLEN-1:0]    mepc_i,
  output logic [XLEN-1:0]    npc_o,
  output logic               redirect_o,
  output logic               misalign_o
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    EXEC
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] pc_br;
  logic [XLEN-1:0] pc_jr;
  logic [XLEN-1:0] target;
  logic            load;
`ifdef NPC_MISALIGN_CHK_EN
  logic            mis;
  logic            mis_q;
`endif

  assign pc_seq = pc + XLEN'(4);
  assign pc_br  = pc + imm_i;
  assign pc_jr  = (rs1_val_i + imm_i) & ~XLEN'(1);
  assign pc_o   = pc;
  assign load   = (state == EXEC) && commit_i;

  // Branch-op target selection; reserved codes fall through to sequential.
  always_comb begin
    target = pc_seq;
    case (branch_op_i)
      3'b001:  target = pc_br;
      3'b010:  target = pc_jr;
      3'b100:  target = zero_i ? pc_br : pc_seq;
      3'b101:  target = zero_i ? pc_seq : pc_br;
      3'b110:  target = less_i ? pc_br : pc_seq;
      3'b111:  target = less_i ? pc_seq : pc_br;
      default: target = pc_seq;
    endcase
  end

  // Final next PC: trap beats mret beats branch resolution.
  always_comb begin
    npc_o = target;
`ifdef NPC_MISALIGN_CHK_EN
    mis = 1'b0;
`endif
    if (trap_i) begin
      npc_o = trap_vec_i;
    end else if (mret_i) begin
      npc_o = mepc_i;
    end else begin
`ifdef NPC_MISALIGN_CHK_EN
      mis = |target[1:0];
      if (mis) npc_o = trap_vec_i;
`endif
    end
  end

  // Next-state and fetch-valid decode.
  always_comb begin
    state_nxt  = state;
    pc_valid_o = 1'b0;
    unique case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: begin
        pc_valid_o = 1'b1;
        if (pc_ready_i) state_nxt = EXEC;
      end
      EXEC:  if (commit_i) state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  // State, PC and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= BOOT;
      pc         <= RESET_VEC;
      redirect_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      redirect_o <= 1'b0;
      if (load) begin
        pc         <= npc_o;
        redirect_o <= (npc_o != pc_seq);
      end
    end
  end

`ifdef NPC_MISALIGN_CHK_EN
  // Misalign pulse lines up with the redirect pulse.
  always_ff @(posedge clk) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= load && mis;
  end
  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_pc_ctrl.sv
// Directed bench for riscv_pc_ctrl: handshake, branch resolve, priority, wrap, reset.
// Expected values are hand-computed per step.
module tb_riscv_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] pc;
  logic        commit;
  logic [2:0]  branch_op;
  logic        zero;
  logic        less;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic        trap;
  logic [31:0] trap_vec;
  logic        mret;
  logic [31:0] mepc;
  logic [31:0] npc;
  logic        redirect;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_pc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .pc_valid_o  (pc_valid),
    .pc_ready_i  (pc_ready),
    .pc_o        (pc),
    .commit_i    (commit),
    .branch_op_i (branch_op),
    .zero_i      (zero),
    .less_i      (less),
    .imm_i       (imm),
    .rs1_val_i   (rs1_val),
    .trap_i      (trap),
    .trap_vec_i  (trap_vec),
    .mret_i      (mret),
    .mepc_i      (mepc),
    .npc_o       (npc),
    .redirect_o  (redirect),
    .misalign_o  (misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    commit    = 1'b0;
    branch_op = 3'b000;
    zero      = 1'b0;
    less      = 1'b0;
    imm       = 32'h0;
    rs1_val   = 32'h0;
    trap      = 1'b0;
    trap_vec  = 32'h0;
    mret      = 1'b0;
    mepc      = 32'h0;
  endtask

  // One full fetch/execute round trip, starting and ending in FETCH.
  task automatic instr(input string tag, input logic [2:0] op,
                       input logic z, input logic l,
                       input logic [31:0] im, input logic [31:0] rs1,
                       input logic tr, input logic [31:0] tv,
                       input logic mr, input logic [31:0] me,
                       input logic [31:0] exp_pc, input logic exp_rd,
                       input logic exp_mis);
    logic [31:0] old_pc;
    old_pc   = pc;
    pc_ready = 1'b1;
    tick();
    chk({tag, "_exec_valid"}, {31'b0, pc_valid}, 32'd0);
    pc_ready  = 1'b0;
    commit    = 1'b1;
    branch_op = op;
    zero      = z;
    less      = l;
    imm       = im;
    rs1_val   = rs1;
    trap      = tr;
    trap_vec  = tv;
    mret      = mr;
    mepc      = me;
    #1;
    chk({tag, "_npc"}, npc, exp_pc);
    chk({tag, "_hold"}, pc, old_pc);
    tick();
    clr_in();
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_valid"}, {31'b0, pc_valid}, 32'd1);
    chk({tag, "_redir"}, {31'b0, redirect}, {31'b0, exp_rd});
    chk({tag, "_mis"}, {31'b0, misalign}, {31'b0, exp_mis});
    tick();
    chk({tag, "_redir_end"}, {31'b0, redirect}, 32'd0);
    chk({tag, "_mis_end"}, {31'b0, misalign}, 32'd0);
    chk({tag, "_pc_stay"}, pc, exp_pc);
  endtask

  initial begin
    rst      = 1'b0;
    pc_ready = 1'b0;
    clr_in();
    tick();
    tick();
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_valid", {31'b0, pc_valid}, 32'd0);
    chk("rst_redir", {31'b0, redirect}, 32'd0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);

    rst = 1'b1;
    tick();
    chk("boot_valid", {31'b0, pc_valid}, 32'd1);
    chk("boot_pc", pc, 32'h8000_0000);

    commit    = 1'b1;
    branch_op = 3'b001;
    imm       = 32'h100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pc", pc, 32'h8000_0000);
      chk("stall_valid", {31'b0, pc_valid}, 32'd1);
      chk("stall_redir", {31'b0, redirect}, 32'd0);
    end
    clr_in();

    instr("jal16", 3'b001, 0, 0, 32'h10, 0, 0, 0, 0, 0,
          32'h8000_0010, 1, 0);
    instr("beq_t", 3'b100, 1, 0, 32'hFFFF_FFF8, 0, 0, 0, 0, 0,
          32'h8000_0008, 1, 0);
    instr("jal8", 3'b001, 0, 0, 32'h8, 0, 0, 0, 0, 0,
          32'h8000_0010, 1, 0);
    instr("beq_nt", 3'b100, 0, 0, 32'hFFFF_FFF8, 0, 0, 0, 0, 0,
          32'h8000_0014, 0, 0);
    instr("bne_t", 3'b101, 0, 0, 32'h20, 0, 0, 0, 0, 0,
          32'h8000_0034, 1, 0);
    instr("blt_t", 3'b110, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0,
          32'h8000_0030, 1, 0);
    instr("bge_nt", 3'b111, 0, 1, 32'h40, 0, 0, 0, 0, 0,
          32'h8000_0034, 0, 0);
    instr("op011", 3'b011, 1, 1, 32'h40, 0, 0, 0, 0, 0,
          32'h8000_0038, 0, 0);
    instr("jalr", 3'b010, 0, 0, 32'h2, 32'h8000_1003, 0, 0, 0, 0,
          32'h8000_1004, 1, 0);
    instr("trap_mret", 3'b001, 0, 0, 32'h4, 0, 1, 32'h8000_0100,
          1, 32'h8000_0200, 32'h8000_0100, 1, 0);
    instr("mret", 3'b001, 0, 0, 32'h4, 0, 0, 32'h8000_0100,
          1, 32'h8000_0200, 32'h8000_0200, 1, 0);
    instr("trap_top", 3'b000, 0, 0, 0, 0, 1, 32'hFFFF_FFFC,
          0, 0, 32'hFFFF_FFFC, 1, 0);
    instr("wrap", 3'b000, 0, 0, 0, 0, 0, 32'h8000_0100,
          0, 0, 32'h0000_0000, 0, 0);
    instr("to_base", 3'b001, 0, 0, 32'h8000_0000, 0, 0, 0, 0, 0,
          32'h8000_0000, 1, 0);
`ifdef NPC_MISALIGN_CHK_EN
    instr("misalign", 3'b001, 0, 0, 32'h2, 0, 0, 32'h8000_0100,
          0, 0, 32'h8000_0100, 1, 1);
`else
    instr("misalign", 3'b001, 0, 0, 32'h2, 0, 0, 32'h8000_0100,
          0, 0, 32'h8000_0002, 1, 0);
`endif

    pc_ready = 1'b1;
    tick();
    chk("mid_exec", {31'b0, pc_valid}, 32'd0);
    pc_ready  = 1'b0;
    rst       = 1'b0;
    commit    = 1'b1;
    branch_op = 3'b001;
    imm       = 32'h40;
    tick();
    clr_in();
    chk("mid_rst_pc", pc, 32'h8000_0000);
    chk("mid_rst_valid", {31'b0, pc_valid}, 32'd0);
    chk("mid_rst_redir", {31'b0, redirect}, 32'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_valid", {31'b0, pc_valid}, 32'd1);
    chk("post_rst_pc", pc, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
